// File: rtl/alu_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_div_seq
//  Description : Multi-cycle 8/8 restoring divider that borrows the core ALU
//                through a req/gnt handshake. Each quotient bit is one ALU
//                subtract, and the ALU's borrow flag selects restore or keep.
//                Optional macro DIV_SIGNED_EN adds the sgn input for
//                two's-complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_div_seq #(
    parameter logic [2:0] OP_SUB  = 3'd6,
    parameter logic [2:0] OP_PASS = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef DIV_SIGNED_EN
    input  logic       sgn,
`endif
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero,
    output logic       alu_req,
    input  logic       alu_gnt,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_carry
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ZCHK = 3'd1,
        S_REQ  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] q_q, q_d;          // dividend shifting out / quotient shifting in
    logic [7:0] d_q, d_d;          // divisor (magnitude once past ZCHK)
    logic [7:0] r_q, r_d;          // partial remainder
    logic [2:0] cnt_q, cnt_d;      // step counter, 7 marks the last step
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       req_q, req_d;
    logic [7:0] quot_q, quot_d;
    logic [7:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic       sgn_q, sgn_d;      // operation is signed
    logic       qneg_q, qneg_d;    // operand signs differ: negate quotient
    logic       rneg_q, rneg_d;    // dividend negative: negate remainder
`endif

    // Per-step combinational helpers
    logic [7:0] step_s;            // shifted partial remainder fed to the ALU
    logic [7:0] step_r;            // partial remainder after this step
    logic [7:0] step_q;            // quotient register after this step

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            q_q     <= 8'h00;
            d_q     <= 8'h00;
            r_q     <= 8'h00;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            quot_q  <= 8'h00;
            rem_q   <= 8'h00;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    // Next-state, datapath update and ALU drive
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        req_d   = req_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        alu_op  = OP_PASS;
        alu_a   = 8'h00;
        alu_b   = 8'h00;

        // Restoring step: a borrow means S < D, so keep S and shift in 0
        step_s  = {r_q[6:0], q_q[7]};
        step_r  = alu_carry ? step_s : alu_result;
        step_q  = {q_q[6:0], ~alu_carry};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = 8'h00;
                    busy_d  = 1'b1;
`ifdef DIV_SIGNED_EN
                    sgn_d   = sgn;
`endif
                    state_d = S_ZCHK;
                end
            end

            S_ZCHK: begin
                if (d_q == 8'h00) begin
                    // q_q still holds the raw dividend here
                    quot_d  = 8'hFF;
                    rem_d   = q_q;
                    dbz_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
`ifdef DIV_SIGNED_EN
                    // Magnitudes are formed locally so the ALU is only
                    // borrowed for the eight subtract steps
                    qneg_d = sgn_q & (q_q[7] ^ d_q[7]);
                    rneg_d = sgn_q & q_q[7];
                    if (sgn_q && q_q[7]) begin
                        q_d = (~q_q) + 8'd1;
                    end
                    if (sgn_q && d_q[7]) begin
                        d_d = (~d_q) + 8'd1;
                    end
`endif
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (alu_gnt) begin
                    cnt_d   = 3'd0;
                    state_d = S_STEP;
                end
            end

            S_STEP: begin
                // Operands stay on the bus through a grant stall; only the
                // register update waits for the grant
                alu_op = OP_SUB;
                alu_a  = step_s;
                alu_b  = d_q;
                if (alu_gnt) begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        quot_d  = step_q;
                        rem_d   = step_r;
`ifdef DIV_SIGNED_EN
                        if (qneg_q) begin
                            quot_d = (~step_q) + 8'd1;
                        end
                        if (rneg_q) begin
                            rem_d = (~step_r) + 8'd1;
                        end
`endif
                        dbz_d   = 1'b0;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Results were latched on entry; done lasts this one cycle
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign alu_req     = req_q;

endmodule
`default_nettype wire
